// File: rtl/edge_detector_pixel_scanner.sv
// Coordinate sequencer for a 3x3 kernel pass: nine neighbour reads
// followed by one centre write for every interior pixel of the image.
module edge_detector_pixel_scanner #(
    parameter int IMG_W   = 100,
    parameter int IMG_H   = 100,
    parameter int X_WIDTH = 7,
    parameter int Y_WIDTH = 7
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               Start_i,
    input  logic               Ready_i,
    output logic               Valid_o,
    output logic [X_WIDTH-1:0] X_o,
    output logic [Y_WIDTH-1:0] Y_o,
    output logic [3:0]         Tap_o,
    output logic               Wr_o,
    output logic               Busy_o,
    output logic               Done_o
);

    localparam int AW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;
    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 2);
    localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 2);
    localparam logic          SIZE_OK = (IMG_W >= 3) && (IMG_H >= 3);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e          state_q;
    logic [AW-1:0]   cr_q, cc_q;
    logic [3:0]      tap_q;
    logic            valid_q, wr_q, busy_q, done_q;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic [3:0]      tapo_q;

    logic [3:0]      tap_d;
    logic [AW-1:0]   rd_x_d, rd_y_d, cr_d, cc_d;
    logic            wrap_d, last_d;

    // Coordinates for the next tap and for the next centre position
    always_comb begin
        tap_d  = tap_q + 4'd1;
        rd_x_d = cr_q + AW'(tap_d / 4'd3) - ONE;
        rd_y_d = cc_q + AW'(tap_d % 4'd3) - ONE;
        wrap_d = (cc_q == LAST_C);
        last_d = wrap_d && (cr_q == LAST_R);
        cc_d   = wrap_d ? ONE : cc_q + ONE;
        cr_d   = wrap_d ? cr_q + ONE : cr_q;
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q <= IDLE;
            cr_q    <= ONE;
            cc_q    <= ONE;
            tap_q   <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            tapo_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Start_i) begin
                        cr_q   <= ONE;
                        cc_q   <= ONE;
                        tap_q  <= '0;
                        busy_q <= 1'b1;
                        if (SIZE_OK) begin
                            state_q <= READ;
                            valid_q <= 1'b1;
                            wr_q    <= 1'b0;
                            x_q     <= '0;
                            y_q     <= '0;
                            tapo_q  <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (Ready_i) begin
                        if (tap_q == 4'd8) begin
                            state_q <= WRITE;
                            tap_q   <= '0;
                            wr_q    <= 1'b1;
                            tapo_q  <= '0;
                            x_q     <= X_WIDTH'(cr_q);
                            y_q     <= Y_WIDTH'(cc_q);
                        end else begin
                            tap_q  <= tap_d;
                            tapo_q <= tap_d;
                            x_q    <= X_WIDTH'(rd_x_d);
                            y_q    <= Y_WIDTH'(rd_y_d);
                        end
                    end
                end
                WRITE: begin
                    if (Ready_i) begin
                        wr_q <= 1'b0;
                        if (last_d) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            cr_q    <= ONE;
                            cc_q    <= ONE;
                            x_q     <= '0;
                            y_q     <= '0;
                        end else begin
                            state_q <= READ;
                            cr_q    <= cr_d;
                            cc_q    <= cc_d;
                            x_q     <= X_WIDTH'(cr_d - ONE);
                            y_q     <= Y_WIDTH'(cc_d - ONE);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Valid_o = valid_q;
    assign X_o     = x_q;
    assign Y_o     = y_q;
    assign Tap_o   = tapo_q;
    assign Wr_o    = wr_q;
    assign Busy_o  = busy_q;
    assign Done_o  = done_q;

endmodule

// File: tb/tb_edge_detector_pixel_scanner.sv
// Directed bench: 4x4, 5x4 and degenerate 2x4 scanners share clock,
// reset and ready; each has its own start.
module tb_edge_detector_pixel_scanner;

    logic       clk;
    logic       rst;
    logic       ready;
    logic       start [3];
    logic       valid [3];
    logic [6:0] xo    [3];
    logic [6:0] yo    [3];
    logic [3:0] tapo  [3];
    logic       wr    [3];
    logic       busy  [3];
    logic       done  [3];

    int n_tests;
    int n_fail;
    int rec [100];
    int v2_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    edge_detector_pixel_scanner #(.IMG_W(4), .IMG_H(4)) u_s4 (
        .Clk_i(clk), .Rst_i(rst), .Start_i(start[0]), .Ready_i(ready),
        .Valid_o(valid[0]), .X_o(xo[0]), .Y_o(yo[0]), .Tap_o(tapo[0]),
        .Wr_o(wr[0]), .Busy_o(busy[0]), .Done_o(done[0]));

    edge_detector_pixel_scanner #(.IMG_W(5), .IMG_H(4)) u_s5 (
        .Clk_i(clk), .Rst_i(rst), .Start_i(start[1]), .Ready_i(ready),
        .Valid_o(valid[1]), .X_o(xo[1]), .Y_o(yo[1]), .Tap_o(tapo[1]),
        .Wr_o(wr[1]), .Busy_o(busy[1]), .Done_o(done[1]));

    edge_detector_pixel_scanner #(.IMG_W(2), .IMG_H(4)) u_s2 (
        .Clk_i(clk), .Rst_i(rst), .Start_i(start[2]), .Ready_i(ready),
        .Valid_o(valid[2]), .X_o(xo[2]), .Y_o(yo[2]), .Tap_o(tapo[2]),
        .Wr_o(wr[2]), .Busy_o(busy[2]), .Done_o(done[2]));

    always @(posedge clk) if (valid[2]) v2_seen++;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packing: x<<12 | y<<5 | tap<<1 | wr
    function automatic int pk(int x, int y, int t, int w);
        return (x << 12) | (y << 5) | (t << 1) | w;
    endfunction

    function automatic int obs(int s);
        return pk(int'(xo[s]), int'(yo[s]), int'(tapo[s]), int'(wr[s]));
    endfunction

    function automatic int outs(int s);
        return obs(s) | (int'(valid[s]) << 20) | (int'(busy[s]) << 21)
            | (int'(done[s]) << 22);
    endfunction

    function automatic int expv(int i, int w);
        int n, k, cr, cc;
        n  = i / 10;
        k  = i % 10;
        cr = 1 + n / (w - 2);
        cc = 1 + n % (w - 2);
        if (k < 9) return pk(cr + k / 3 - 1, cc + k % 3 - 1, k, 0);
        return pk(cr, cc, 0, 1);
    endfunction

    task automatic scan(input int s, input int w, input int h,
                        input bit stall, input bit poke);
        int idx, cyc, stalled, bubbles, total;
        bit got_done;
        total = 10 * (w - 2) * (h - 2);
        idx = 0; cyc = 0; stalled = 0; bubbles = 0; got_done = 0;
        @(negedge clk); start[s] = 1'b1;
        @(negedge clk); start[s] = 1'b0;
        chk("latency", int'(valid[s]), 1);
        while (!got_done && cyc < 3000) begin
            if (done[s]) begin
                got_done = 1'b1;
                chk("done_idx", idx, total);
                chk("done_valid", int'(valid[s]), 0);
            end else begin
                if (!valid[s]) bubbles++;
                ready = 1'b1;
                if (stall && valid[s] && !wr[s] && tapo[s] == 4'd5
                    && stalled < 3) begin
                    ready = 1'b0;
                    stalled++;
                end
                if (poke) start[s] = (cyc == 15);
                if (valid[s]) begin
                    chk($sformatf("txn%0d", idx), obs(s), expv(idx, w));
                    if (ready) begin
                        if (idx < 100) rec[idx] = obs(s);
                        idx++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        start[s] = 1'b0;
        ready = 1'b1;
        chk("done_seen", int'(got_done), 1);
        chk("bubbles", bubbles, 0);
        chk("stalls", stalled, stall ? 3 : 0);
        chk("cycles", cyc, total + (stall ? 3 : 0));
        @(negedge clk);
        chk("done_1cyc", int'(done[s]), 0);
        chk("busy_end", int'(busy[s]), 0);
    endtask

    initial begin
        int hx [10];
        int hy [10];
        bit found;
        n_tests = 0; n_fail = 0; v2_seen = 0;
        ready = 1'b1;
        for (int s = 0; s < 3; s++) start[s] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) chk("rst_outs", outs(s), 0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outs", outs(0) | outs(1) | outs(2), 0);
        end

        // Degenerate width: immediate done, no transactions
        @(negedge clk); start[2] = 1'b1;
        @(negedge clk); start[2] = 1'b0;
        chk("deg_done", int'(done[2]), 1);
        chk("deg_valid", int'(valid[2]), 0);
        chk("deg_busy", int'(busy[2]), 1);
        @(negedge clk);
        chk("deg_done_off", int'(done[2]), 0);
        chk("deg_idle", int'(busy[2]), 0);

        scan(0, 4, 4, 1'b0, 1'b0);
        hx = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 1};
        hy = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 1};
        for (int i = 0; i < 9; i++)
            chk($sformatf("first_rd%0d", i), rec[i], pk(hx[i], hy[i], i, 0));
        chk("first_wr", rec[9], pk(hx[9], hy[9], 0, 1));
        chk("last_wr4", rec[39], pk(2, 2, 0, 1));

        scan(0, 4, 4, 1'b1, 1'b0);
        chk("stall_tap5", rec[5], pk(1, 2, 5, 0));
        chk("stall_tap6", rec[6], pk(2, 0, 6, 0));

        scan(1, 5, 4, 1'b0, 1'b1);
        chk("wrap_wr3", rec[29], pk(1, 3, 0, 1));
        chk("wrap_rd", rec[30], pk(1, 0, 0, 0));
        chk("last_wr5", rec[59], pk(2, 3, 0, 1));

        // Reset during the write of centre (1,2)
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (valid[0] && wr[0] && xo[0] == 7'd1 && yo[0] == 7'd2)
                found = 1'b1;
            else
                @(negedge clk);
        end
        chk("wr12_found", int'(found), 1);
        #2 rst = 1'b1;
        #1 chk("async_rst", outs(0), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst", outs(0), 0);
        scan(0, 4, 4, 1'b0, 1'b0);

        chk("deg_never_valid", v2_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
